// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus widths and load-type encodings.
// These play the role of the mycpu.h definitions for the rest of the pipeline.
package mem_stage_pkg;

   localparam int ES_TO_MS_BUS_WD = 74;
   localparam int MS_TO_WS_BUS_WD = 70;

   // Codes 5-7 are unassigned and fall back to a full-word load.
   typedef enum logic [2:0] {
      LD_LW  = 3'd0,
      LD_LB  = 3'd1,
      LD_LBU = 3'd2,
      LD_LH  = 3'd3,
      LD_LHU = 3'd4
   } ld_type_e;

endpackage

// File: rtl/mem_load_align.sv
// Combinational extraction of a byte/halfword/word from the SRAM read word.
// Misaligned addresses are not trapped: halfwords ignore addr[0] and words ignore addr.
module mem_load_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]  ld_type,
   input  logic [1:0]  addr,
   input  logic [31:0] rdata,
   output logic [31:0] value
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase

      half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

      case (ld_type_e'(ld_type))
         LD_LB:   value = {{24{byte_sel[7]}}, byte_sel};
         LD_LBU:  value = {24'd0, byte_sel};
         LD_LH:   value = {{16{half_sel[15]}}, half_sel};
         LD_LHU:  value = {16'd0, half_sel};
         default: value = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: one-entry valid/bus register with ready/allow handshake,
// load data alignment and forwarding outputs for the decode stage.
module mem_stage #(
   parameter int ES_TO_MS_BUS_WD = mem_stage_pkg::ES_TO_MS_BUS_WD,
   parameter int MS_TO_WS_BUS_WD = mem_stage_pkg::MS_TO_WS_BUS_WD
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   input  logic [31:0]                data_sram_rdata,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic [4:0]                 ms_real_dest,
   output logic [31:0]                ms_forward_data
);

   import mem_stage_pkg::*;

   logic                       ms_valid;
   logic                       ms_ready_go;
   logic [ES_TO_MS_BUS_WD-1:0] bus_r;

   logic [2:0]  ld_type;
   logic        res_from_mem;
   logic        gr_we;
   logic [4:0]  dest;
   logic [31:0] alu_result;
   logic [31:0] pc;
   logic [31:0] load_value;
   logic [31:0] final_result;

   // The SRAM answers in a fixed cycle, so MEM never needs to wait.
   assign ms_ready_go    = 1'b1;
   assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid && ms_ready_go;

   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid <= 1'b0;
      end else if (ms_allowin) begin
         ms_valid <= es_to_ms_valid;
      end
   end

   // Clearing the payload on reset keeps the WB bus and forwarding data at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus_r <= '0;
      end else if (es_to_ms_valid && ms_allowin) begin
         bus_r <= es_to_ms_bus;
      end
   end

   assign {ld_type, res_from_mem, gr_we, dest, alu_result, pc} = bus_r;

   mem_load_align u_load_align (
      .ld_type (ld_type),
      .addr    (alu_result[1:0]),
      .rdata   (data_sram_rdata),
      .value   (load_value)
   );

   assign final_result    = res_from_mem ? load_value : alu_result;
   assign ms_to_ws_bus    = {gr_we, dest, final_result, pc};
   assign ms_real_dest    = (ms_valid && gr_we) ? dest : 5'd0;
   assign ms_forward_data = final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset state, load extraction,
// forwarding, stall/handoff, back-to-back throughput and reset during a stall.
module tb_mem_stage;

   logic        clk;
   logic        reset;
   logic        ws_allowin;
   logic        ms_allowin;
   logic        es_to_ms_valid;
   logic [73:0] es_to_ms_bus;
   logic [31:0] data_sram_rdata;
   logic        ms_to_ws_valid;
   logic [69:0] ms_to_ws_bus;
   logic [4:0]  ms_real_dest;
   logic [31:0] ms_forward_data;

   int checks = 0;
   int errors = 0;

   mem_stage dut (
      .clk             (clk),
      .reset           (reset),
      .ws_allowin      (ws_allowin),
      .ms_allowin      (ms_allowin),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_to_ms_bus    (es_to_ms_bus),
      .data_sram_rdata (data_sram_rdata),
      .ms_to_ws_valid  (ms_to_ws_valid),
      .ms_to_ws_bus    (ms_to_ws_bus),
      .ms_real_dest    (ms_real_dest),
      .ms_forward_data (ms_forward_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [73:0] make_bus(input logic [2:0] ld, input logic rfm,
                                            input logic we, input logic [4:0] dst,
                                            input logic [31:0] alu, input logic [31:0] pc);
      return {ld, rfm, we, dst, alu, pc};
   endfunction

   task automatic checkOutput(input string tag, input logic [69:0] observed,
                              input logic [69:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one instruction for a single edge, then withdraw it.
   task automatic applyStimulus(input logic [73:0] bus);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = bus;
      tick();
      es_to_ms_valid = 1'b0;
   endtask

   task automatic runLoad(input string tag, input logic [2:0] ld, input logic [31:0] alu,
                          input logic [31:0] expected);
      applyStimulus(make_bus(ld, 1'b1, 1'b1, 5'd7, alu, 32'hBFC0_1000));
      checkOutput({tag, "_valid"}, 70'(ms_to_ws_valid), 70'(1'b1));
      checkOutput({tag, "_bus"}, ms_to_ws_bus, {1'b1, 5'd7, expected, 32'hBFC0_1000});
      checkOutput({tag, "_fwd"}, 70'(ms_forward_data), 70'(expected));
   endtask

   initial begin
      reset           = 1'b1;
      ws_allowin      = 1'b1;
      es_to_ms_valid  = 1'b0;
      es_to_ms_bus    = '0;
      data_sram_rdata = 32'hAAAA_5555;
      tick();
      tick();
      reset = 1'b0;

      checkOutput("rst_valid", 70'(ms_to_ws_valid), 70'(1'b0));
      checkOutput("rst_allowin", 70'(ms_allowin), 70'(1'b1));
      checkOutput("rst_real_dest", 70'(ms_real_dest), 70'(5'd0));
      checkOutput("rst_bus", ms_to_ws_bus, 70'd0);
      checkOutput("rst_fwd", 70'(ms_forward_data), 70'd0);

      // Load extraction against rdata = 0x80FF_1234.
      data_sram_rdata = 32'h80FF_1234;
      runLoad("lb_3",     3'd1, 32'h0000_1003, 32'hFFFF_FF80);
      runLoad("lbu_3",    3'd2, 32'h0000_1003, 32'h0000_0080);
      runLoad("lb_2",     3'd1, 32'h0000_1002, 32'hFFFF_FFFF);
      runLoad("lbu_0",    3'd2, 32'h0000_1000, 32'h0000_0034);
      runLoad("lb_1",     3'd1, 32'h0000_1001, 32'h0000_0012);
      runLoad("lhu_2",    3'd4, 32'h0000_1002, 32'h0000_80FF);
      runLoad("lh_2",     3'd3, 32'h0000_1002, 32'hFFFF_80FF);
      runLoad("lh_mis1",  3'd3, 32'h0000_1001, 32'h0000_1234);
      runLoad("lh_mis3",  3'd3, 32'h0000_1003, 32'hFFFF_80FF);
      runLoad("lw_mis1",  3'd0, 32'h0000_1001, 32'h80FF_1234);
      runLoad("ld6_as_lw",3'd6, 32'h0000_1000, 32'h80FF_1234);

      // Non-load results bypass rdata entirely.
      applyStimulus(make_bus(3'd1, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'hBFC0_2000));
      checkOutput("alu_bus", ms_to_ws_bus, {1'b1, 5'd5, 32'hDEAD_BEEF, 32'hBFC0_2000});
      checkOutput("alu_real_dest", 70'(ms_real_dest), 70'(5'd5));
      checkOutput("alu_fwd", 70'(ms_forward_data), 70'(32'hDEAD_BEEF));
      applyStimulus(make_bus(3'd0, 1'b0, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'hBFC0_2004));
      checkOutput("nowe_real_dest", 70'(ms_real_dest), 70'(5'd0));
      checkOutput("nowe_fwd", 70'(ms_forward_data), 70'(32'hDEAD_BEEF));

      // Drain with nothing new: register still holds gr_we=1 but valid is low.
      applyStimulus(make_bus(3'd0, 1'b0, 1'b1, 5'd9, 32'h0000_0011, 32'hBFC0_2008));
      tick();
      checkOutput("drain_valid", 70'(ms_to_ws_valid), 70'(1'b0));
      checkOutput("drain_real_dest", 70'(ms_real_dest), 70'(5'd0));

      // Stall for 3 cycles while EXE keeps offering a younger instruction.
      applyStimulus(make_bus(3'd0, 1'b0, 1'b1, 5'd4, 32'h0000_0100, 32'hBFC0_0100));
      ws_allowin     = 1'b0;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = make_bus(3'd0, 1'b0, 1'b1, 5'd6, 32'h0000_0104, 32'hBFC0_0104);
      #1;
      checkOutput("stall_allowin", 70'(ms_allowin), 70'(1'b0));
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("stall_valid", 70'(ms_to_ws_valid), 70'(1'b1));
         checkOutput("stall_bus", ms_to_ws_bus, {1'b1, 5'd4, 32'h0000_0100, 32'hBFC0_0100});
         checkOutput("stall_allowin_hold", 70'(ms_allowin), 70'(1'b0));
      end
      ws_allowin     = 1'b1;
      es_to_ms_valid = 1'b0;
      #1;
      checkOutput("release_allowin", 70'(ms_allowin), 70'(1'b1));
      tick();
      checkOutput("release_single_handoff", 70'(ms_to_ws_valid), 70'(1'b0));

      // Back-to-back: one instruction per cycle, in order.
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = make_bus(3'd0, 1'b0, 1'b1, 5'd1, 32'h0000_0001, 32'hBFC0_0000);
      tick();
      checkOutput("b2b0_valid", 70'(ms_to_ws_valid), 70'(1'b1));
      checkOutput("b2b0_pc", 70'(ms_to_ws_bus[31:0]), 70'(32'hBFC0_0000));
      es_to_ms_bus   = make_bus(3'd0, 1'b0, 1'b1, 5'd2, 32'h0000_0002, 32'hBFC0_0004);
      tick();
      checkOutput("b2b1_valid", 70'(ms_to_ws_valid), 70'(1'b1));
      checkOutput("b2b1_pc", 70'(ms_to_ws_bus[31:0]), 70'(32'hBFC0_0004));
      es_to_ms_bus   = make_bus(3'd0, 1'b0, 1'b1, 5'd3, 32'h0000_0003, 32'hBFC0_0008);
      tick();
      checkOutput("b2b2_valid", 70'(ms_to_ws_valid), 70'(1'b1));
      checkOutput("b2b2_pc", 70'(ms_to_ws_bus[31:0]), 70'(32'hBFC0_0008));
      es_to_ms_valid = 1'b0;
      tick();
      checkOutput("b2b_end_valid", 70'(ms_to_ws_valid), 70'(1'b0));

      // Reset during a stall, with EXE still offering an instruction.
      applyStimulus(make_bus(3'd0, 1'b0, 1'b1, 5'd12, 32'h0000_0200, 32'hBFC0_0200));
      ws_allowin     = 1'b0;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = make_bus(3'd0, 1'b1, 1'b1, 5'd13, 32'h0000_0204, 32'hBFC0_0204);
      tick();
      checkOutput("pre_rst_stall_dest", 70'(ms_real_dest), 70'(5'd12));
      reset = 1'b1;
      tick();
      checkOutput("midrst_valid", 70'(ms_to_ws_valid), 70'(1'b0));
      checkOutput("midrst_real_dest", 70'(ms_real_dest), 70'(5'd0));
      checkOutput("midrst_allowin", 70'(ms_allowin), 70'(1'b1));
      checkOutput("midrst_bus", ms_to_ws_bus, 70'd0);
      reset          = 1'b0;
      es_to_ms_valid = 1'b0;
      ws_allowin     = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
